// File: rtl/seg7_pkg.sv
// Shared seven-segment package: digit/nibble widths, display value and payload types.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

  typedef logic [DIGIT_W-1:0]    digit_t;
  typedef logic [NIBBLE_W-1:0]   nibble_t;
  typedef logic [VALUE_W-1:0]    value_t;
  typedef logic [NUM_DIGITS-1:0] dots_t;

  // Value plus its decimal points, latched and displayed as one unit
  typedef struct packed {
    value_t value;
    dots_t  dots;
  } disp_t;

  // Nibble belonging to digit d (digit 0 is the rightmost)
  function automatic nibble_t nibble_of(value_t v, digit_t d);
    return v[{d, 2'b00} +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load handshake and decoder-drive signals of the seven-segment scan driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  value_t  VALUE_IN;
  dots_t   DOTS_IN;
  logic    LOAD_IN;
  logic    LOAD_ACK_OUT;
  digit_t  SEG_SELECT_OUT;
  nibble_t BIN_OUT;
  logic    DOT_OUT;
  logic    BLANK_OUT;

  modport master (
    output VALUE_IN, DOTS_IN, LOAD_IN,
    input  LOAD_ACK_OUT, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT
  );

  modport slave (
    input  VALUE_IN, DOTS_IN, LOAD_IN,
    output LOAD_ACK_OUT, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT
  );
endinterface

// File: rtl/seg7_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 and flags the last count of each digit slot.
module seg7_tick_gen #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  // With CLK_DIV=1 the counter sits at 0 and tick stays high
  assign tick = (count == LAST);

  // Free-running wrap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit seven-segment scan controller with frame-aligned load/ack handshake.
// Optional leading-zero blanking is built when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic               CLK,
  input  logic               RESET,
  seg7_scan_driver_if.slave  bus
);

  logic    tick;
  logic    wrap_c;
  digit_t  digit, digit_nxt;
  disp_t   active, active_nxt;
  disp_t   pend, pend_nxt;
  disp_t   load_c;
  logic    flag, flag_nxt;
  logic    ack_arm, ack_arm_nxt;
  logic    ack;
  digit_t  sel, sel_nxt;
  nibble_t bin, bin_nxt;
  logic    dot, dot_nxt;

  seg7_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (CLK),
    .rst  (RESET),
    .tick (tick)
  );

  assign load_c = '{value: bus.VALUE_IN, dots: bus.DOTS_IN};

  // Next scan position and handshake state; loads land in active only at the frame wrap
  always_comb begin
    digit_nxt   = digit;
    active_nxt  = active;
    pend_nxt    = pend;
    flag_nxt    = flag;
    ack_arm_nxt = 1'b0;
    wrap_c      = tick && (digit == DIGIT_W'(NUM_DIGITS - 1));
    if (tick) begin
      digit_nxt = digit + DIGIT_W'(1);
    end
    if (wrap_c) begin
      if (bus.LOAD_IN) begin
        active_nxt  = load_c;
        ack_arm_nxt = 1'b1;
      end else if (flag) begin
        active_nxt  = pend;
        ack_arm_nxt = 1'b1;
      end
      flag_nxt = 1'b0;
    end else if (bus.LOAD_IN) begin
      pend_nxt = load_c;
      flag_nxt = 1'b1;
    end
  end

  // State registers; the ack is armed on the wrap edge and issued one edge later
  always_ff @(posedge CLK) begin
    if (RESET) begin
      digit   <= '0;
      active  <= '0;
      pend    <= '0;
      flag    <= 1'b0;
      ack_arm <= 1'b0;
      ack     <= 1'b0;
    end else begin
      digit   <= digit_nxt;
      active  <= active_nxt;
      pend    <= pend_nxt;
      flag    <= flag_nxt;
      ack_arm <= ack_arm_nxt;
      ack     <= ack_arm;
    end
  end

  // Decoder drive for the digit that becomes current on this edge
  always_comb begin
    sel_nxt = digit_nxt;
    bin_nxt = nibble_of(active_nxt.value, digit_nxt);
    dot_nxt = active_nxt.dots[digit_nxt];
  end

  // Output registers move together with the digit counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel <= '0;
      bin <= '0;
      dot <= 1'b0;
    end else begin
      sel <= sel_nxt;
      bin <= bin_nxt;
      dot <= dot_nxt;
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  logic blank, blank_nxt;

  // Blank a non-rightmost digit when it and every higher nibble are zero and its dot is off
  always_comb begin
    blank_nxt = 1'b0;
    unique case (digit_nxt)
      2'd1:    blank_nxt = (active_nxt.value[15:4]  == '0) && !active_nxt.dots[1];
      2'd2:    blank_nxt = (active_nxt.value[15:8]  == '0) && !active_nxt.dots[2];
      2'd3:    blank_nxt = (active_nxt.value[15:12] == '0) && !active_nxt.dots[3];
      default: blank_nxt = 1'b0;
    endcase
  end

  // Blank flag registered alongside the digit outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      blank <= 1'b0;
    end else begin
      blank <= blank_nxt;
    end
  end

  assign bus.BLANK_OUT = blank;
`else
  assign bus.BLANK_OUT = 1'b0;
`endif

  assign bus.LOAD_ACK_OUT   = ack;
  assign bus.SEG_SELECT_OUT = sel;
  assign bus.BIN_OUT        = bin;
  assign bus.DOT_OUT        = dot;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with CLK_DIV=4 (frame = 16 cycles).
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;
`ifdef SEG7_SCAN_LZB_EN
  localparam int LZB = 1;
`else
  localparam int LZB = 0;
`endif

  logic clk;
  logic rst;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.CLK_DIV(DIV)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: k counts edges since reset release; everything follows from k
  int        k = 0;
  bit        m_valid = 0;
  bit [15:0] m_val = '0;
  bit [3:0]  m_dots = '0;
  bit [15:0] p_val = '0;
  bit [3:0]  p_dots = '0;
  bit        p_set = 0;
  bit        ack_due = 0;
  bit        m_ack = 0;

  always @(posedge clk) begin
    m_valid = 1;
    if (rst) begin
      k = 0; m_val = '0; m_dots = '0; p_val = '0; p_dots = '0;
      p_set = 0; ack_due = 0; m_ack = 0;
    end else begin
      k++;
      m_ack   = ack_due;
      ack_due = 0;
      if (k % FRAME == 0) begin
        if (bus.LOAD_IN) begin
          m_val = bus.VALUE_IN; m_dots = bus.DOTS_IN; ack_due = 1;
        end else if (p_set) begin
          m_val = p_val; m_dots = p_dots; ack_due = 1;
        end
        p_set = 0;
      end else if (bus.LOAD_IN) begin
        p_val = bus.VALUE_IN; p_dots = bus.DOTS_IN; p_set = 1;
      end
    end
  end

  // Compare every cycle against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      int d;
      int blank_exp;
      d = (k / DIV) % 4;
      blank_exp = (LZB != 0 && d != 0 && (m_val >> (4 * d)) == 0 && m_dots[d] == 1'b0) ? 1 : 0;
      check("model_sel",   int'(bus.SEG_SELECT_OUT), d);
      check("model_bin",   int'(bus.BIN_OUT), int'((m_val >> (4 * d)) & 16'hF));
      check("model_dot",   int'(bus.DOT_OUT), int'(m_dots[d]));
      check("model_ack",   int'(bus.LOAD_ACK_OUT), int'(m_ack));
      check("model_blank", int'(bus.BLANK_OUT), blank_exp);
    end
  end

  // Advance to the falling edge where the model's edge count equals t
  task automatic goto(input int t);
    int guard;
    guard = 0;
    while (k != t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      fails++;
      tests++;
      $display("FAIL goto_timeout: got k=%0d expected k=%0d", k, t);
    end
  endtask

  // One-cycle load pulse, sampled on the next rising edge
  task automatic do_load(input logic [15:0] v, input logic [3:0] dt);
    bus.VALUE_IN = v;
    bus.DOTS_IN  = dt;
    bus.LOAD_IN  = 1'b1;
    @(negedge clk);
    bus.LOAD_IN  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.VALUE_IN = '0;
    bus.DOTS_IN  = '0;
    bus.LOAD_IN  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and plain scanning
    check("rst_sel", int'(bus.SEG_SELECT_OUT), 0);
    check("rst_bin", int'(bus.BIN_OUT), 0);
    check("rst_ack", int'(bus.LOAD_ACK_OUT), 0);
    goto(4);  check("scan_sel1", int'(bus.SEG_SELECT_OUT), 1);
    goto(8);  check("scan_sel2", int'(bus.SEG_SELECT_OUT), 2);
    goto(12); check("scan_sel3", int'(bus.SEG_SELECT_OUT), 3);
    goto(16); check("scan_wrap_sel", int'(bus.SEG_SELECT_OUT), 0);
    goto(17); check("scan_no_ack", int'(bus.LOAD_ACK_OUT), 0);

    // Mid-frame load of 0x1234, dots 0100
    goto(20); do_load(16'h1234, 4'b0100);
    goto(32); check("l1_bin_d0", int'(bus.BIN_OUT), 4);
              check("l1_ack_wrap_edge", int'(bus.LOAD_ACK_OUT), 0);
    goto(33); check("l1_ack", int'(bus.LOAD_ACK_OUT), 1);
    goto(34); check("l1_ack_end", int'(bus.LOAD_ACK_OUT), 0);
    goto(36); check("l1_bin_d1", int'(bus.BIN_OUT), 3);
              check("l1_dot_d1", int'(bus.DOT_OUT), 0);
    goto(40); check("l1_bin_d2", int'(bus.BIN_OUT), 2);
              check("l1_dot_d2", int'(bus.DOT_OUT), 1);
    goto(44); check("l1_bin_d3", int'(bus.BIN_OUT), 1);
    goto(49); check("l1_no_second_ack", int'(bus.LOAD_ACK_OUT), 0);

    // Two loads in one frame: last wins, single ack
    goto(50); do_load(16'hAAAA, 4'b0000);
    goto(55); do_load(16'h5555, 4'b0000);
    goto(64); check("l2_bin_d0", int'(bus.BIN_OUT), 5);
    goto(65); check("l2_ack", int'(bus.LOAD_ACK_OUT), 1);
    goto(66); check("l2_ack_end", int'(bus.LOAD_ACK_OUT), 0);
    goto(76); check("l2_bin_d3", int'(bus.BIN_OUT), 5);

    // Load coincident with the wrap tick
    goto(79); do_load(16'h9876, 4'b0001);
    check("l3_bin_d0", int'(bus.BIN_OUT), 6);
    check("l3_dot_d0", int'(bus.DOT_OUT), 1);
    goto(81); check("l3_ack", int'(bus.LOAD_ACK_OUT), 1);
    goto(84); check("l3_bin_d1", int'(bus.BIN_OUT), 7);

    // Leading-zero blanking, value 0x0070
    goto(85); do_load(16'h0070, 4'b0000);
    goto(96);  check("b1_blank_d0", int'(bus.BLANK_OUT), 0);
    goto(100); check("b1_blank_d1", int'(bus.BLANK_OUT), 0);
               check("b1_bin_d1", int'(bus.BIN_OUT), 7);
    // Value 0x0000 with dot on digit 3
    do_load(16'h0000, 4'b1000);
    goto(104); check("b1_blank_d2", int'(bus.BLANK_OUT), LZB);
    goto(108); check("b1_blank_d3", int'(bus.BLANK_OUT), LZB);
    goto(112); check("b2_blank_d0", int'(bus.BLANK_OUT), 0);
    goto(116); check("b2_blank_d1", int'(bus.BLANK_OUT), LZB);
    goto(120); check("b2_blank_d2", int'(bus.BLANK_OUT), LZB);
    goto(124); check("b2_blank_d3", int'(bus.BLANK_OUT), 0);
               check("b2_dot_d3", int'(bus.DOT_OUT), 1);

    // Reset at digit 2 with a load pending
    goto(134); do_load(16'hBEEF, 4'b1111);
    goto(137); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("r_sel", int'(bus.SEG_SELECT_OUT), 0);
    check("r_bin", int'(bus.BIN_OUT), 0);
    check("r_dot", int'(bus.DOT_OUT), 0);
    check("r_blank", int'(bus.BLANK_OUT), 0);
    goto(16); check("r_wrap_bin", int'(bus.BIN_OUT), 0);
    goto(17); check("r_no_ack", int'(bus.LOAD_ACK_OUT), 0);
    goto(24); check("r_bin_d2", int'(bus.BIN_OUT), 0);
              check("r_dot_d2", int'(bus.DOT_OUT), 0);
    goto(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
